// File: rtl/off_chip_emulator.sv
// Device-side model of a front-end readout ASIC: BCID/L1ID counters, a trigger FIFO,
// a serial command receiver and a parity-protected event-frame serializer.
module off_chip_emulator #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  CMD_ECR    = 8'hA5,
  parameter logic [7:0]  CMD_BCR    = 8'h3C,
  parameter logic [7:0]  CMD_FLUSH  = 8'h5A
) (
  input  logic clkin40,
  input  logic rst,
  input  logic trigger,
  input  logic command,
  output logic dataout
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt  = FIFO_DEPTH[AW:0];
  localparam logic [4:0]  FrameLen  = 5'd19;
  localparam logic [3:0]  RxDecode  = 4'd9;

  logic [7:0]    bcid_q, l1id_q;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [AW:0]   fill;
  logic          fifo_empty, fifo_full;
  logic [3:0]    rx_cnt_q;
  logic [7:0]    rx_code_q;
  logic          decode, do_ecr, do_bcr, do_flush;
  logic [18:0]   shreg_q;
  logic [4:0]    bits_left_q;
  logic          ser_ready, pop, push;
  logic [15:0]   head_rec;
  logic [18:0]   frame;

  assign decode     = (rx_cnt_q == RxDecode);
  assign do_ecr     = decode && (rx_code_q == CMD_ECR);
  assign do_bcr     = decode && (rx_code_q == CMD_BCR);
  assign do_flush   = decode && (rx_code_q == CMD_FLUSH);

  assign fill       = wptr_q - rptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == DepthCnt);

  // Serializer can take a new record on the edge that emits the guard bit,
  // which keeps backlogged frames exactly FrameLen cycles apart.
  assign ser_ready  = (bits_left_q <= 5'd1);
  assign pop        = ser_ready && !fifo_empty && !do_flush;
  assign push       = trigger && !do_flush && (!fifo_full || pop);

  assign head_rec   = fifo_mem[rptr_q[AW-1:0]];
  assign frame      = {1'b1, head_rec, ^head_rec, 1'b0};

  always_ff @(posedge clkin40 or negedge rst) begin
    if (!rst) begin
      bcid_q <= '0;
      l1id_q <= '0;
    end else begin
      bcid_q <= do_bcr ? 8'd0 : bcid_q + 8'd1;
      if (do_ecr) begin
        l1id_q <= 8'd0;
      end else if (trigger) begin
        l1id_q <= l1id_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clkin40 or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (do_flush) begin
      rptr_q <= wptr_q;
    end else begin
      if (push) begin
        fifo_mem[wptr_q[AW-1:0]] <= {l1id_q, bcid_q};
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // rx_cnt_q: 0 idle, 1..8 shifting code bits, 9 decode.
  always_ff @(posedge clkin40 or negedge rst) begin
    if (!rst) begin
      rx_cnt_q  <= '0;
      rx_code_q <= '0;
    end else if (rx_cnt_q == 4'd0) begin
      if (command) begin
        rx_cnt_q <= 4'd1;
      end
    end else if (decode) begin
      rx_cnt_q <= 4'd0;
    end else begin
      rx_code_q <= {rx_code_q[6:0], command};
      rx_cnt_q  <= rx_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clkin40 or negedge rst) begin
    if (!rst) begin
      shreg_q     <= '0;
      bits_left_q <= '0;
      dataout     <= 1'b0;
    end else begin
      dataout <= (bits_left_q != 5'd0) ? shreg_q[18] : 1'b0;
      if (pop) begin
        shreg_q     <= frame;
        bits_left_q <= FrameLen;
      end else if (bits_left_q != 5'd0) begin
        shreg_q     <= {shreg_q[17:0], 1'b0};
        bits_left_q <= bits_left_q - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_off_chip_emulator.sv
// Bench for off_chip_emulator: queue-based reference model compared every cycle,
// a frame monitor, directed scenarios with literal expectations and a random phase.
module tb_off_chip_emulator;

  localparam int unsigned Depth = 8;
  localparam logic [7:0] Ecr   = 8'hA5;
  localparam logic [7:0] Bcr   = 8'h3C;
  localparam logic [7:0] Flush = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0;
  logic command = 1'b0;
  logic dataout;

  int n_checks = 0;
  int n_err = 0;

  off_chip_emulator #(
    .FIFO_DEPTH(Depth),
    .CMD_ECR(Ecr),
    .CMD_BCR(Bcr),
    .CMD_FLUSH(Flush)
  ) dut (
    .clkin40(clk),
    .rst(rst),
    .trigger(trigger),
    .command(command),
    .dataout(dataout)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [7:0]    m_bcid, m_l1id;
  logic [15:0] m_fifo[$];
  bit          m_bits[$];
  int          rx_state;
  bit [7:0]    rx_code;
  logic        exp_out = 1'b0;
  int          cyc = 0;

  always @(posedge clk or negedge rst) begin : model
    bit decode, flush, ready;
    logic [15:0] rec;
    if (!rst) begin
      m_bcid = 0; m_l1id = 0; m_fifo.delete(); m_bits.delete();
      rx_state = 0; rx_code = 0; exp_out = 1'b0; cyc = 0;
    end else begin
      decode = (rx_state == 9);
      flush  = decode && (rx_code == Flush);
      if (m_bits.size() > 0) exp_out = m_bits.pop_front();
      else exp_out = 1'b0;
      ready = (m_bits.size() == 0);
      if (ready && m_fifo.size() > 0 && !flush) begin
        rec = m_fifo.pop_front();
        m_bits.push_back(1'b1);
        for (int i = 15; i >= 0; i--) m_bits.push_back(rec[i]);
        m_bits.push_back(^rec);
        m_bits.push_back(1'b0);
      end
      if (flush) m_fifo.delete();
      else if (trigger && m_fifo.size() < Depth) m_fifo.push_back({m_l1id, m_bcid});
      if (decode && rx_code == Bcr) m_bcid = 0;
      else m_bcid = m_bcid + 1;
      if (decode && rx_code == Ecr) m_l1id = 0;
      else if (trigger) m_l1id = m_l1id + 1;
      if (rx_state == 0) begin
        if (command) rx_state = 1;
      end else if (rx_state == 9) begin
        rx_state = 0;
      end else begin
        rx_code = {rx_code[6:0], command};
        rx_state++;
      end
      cyc++;
    end
  end

  // Frame monitor on the DUT output
  typedef struct {
    int l1;
    int bc;
    int st;
  } frame_t;
  frame_t frames[$];
  int mon_cnt = 0;
  int mon_st = 0;
  logic [17:0] mon_sh;

  always @(negedge clk) begin : compare
    frame_t f;
    n_checks++;
    if (dataout !== exp_out) begin
      n_err++;
      $display("FAIL dataout cyc=%0d: got %b expected %b", cyc, dataout, exp_out);
    end
    if (!rst) begin
      mon_cnt = 0;
    end else if (mon_cnt == 0) begin
      if (dataout === 1'b1) begin
        mon_cnt = 1;
        mon_st = cyc - 1;
        mon_sh = '0;
      end
    end else begin
      mon_sh = {mon_sh[16:0], dataout};
      mon_cnt++;
      if (mon_cnt == 19) begin
        n_checks++;
        if (mon_sh[1] !== ^mon_sh[17:2] || mon_sh[0] !== 1'b0) begin
          n_err++;
          $display("FAIL frame_parity_guard: got par=%b guard=%b expected par=%b guard=0",
                   mon_sh[1], mon_sh[0], ^mon_sh[17:2]);
        end
        f.l1 = int'(mon_sh[17:10]);
        f.bc = int'(mon_sh[9:2]);
        f.st = mon_st;
        frames.push_back(f);
        mon_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input int idx, input int l1, input int bc);
    if (frames.size() <= idx) begin
      chk({name, "_present"}, frames.size(), idx + 1);
    end else begin
      chk({name, "_l1id"}, frames[idx].l1, l1);
      chk({name, "_bcid"}, frames[idx].bc, bc);
    end
  endtask

  task automatic chk_start(input string name, input int idx, input int st);
    if (frames.size() <= idx) chk({name, "_present"}, frames.size(), idx + 1);
    else chk(name, frames[idx].st, st);
  endtask

  task automatic step(input logic t, input logic c);
    trigger = t;
    command = c;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    trigger = 1'b0;
    command = 1'b0;
    #1;
    chk("reset_dataout", int'(dataout), 0);
    repeat (2) @(negedge clk);
    #1;
    frames.delete();
    rst = 1'b1;
  endtask

  // Start bit, 8 code bits MSB first, then the decode edge.
  task automatic send_cmd(input logic [7:0] code, input bit rnd_trig);
    step(rnd_trig && ($urandom_range(0, 3) == 0), 1'b1);
    for (int i = 7; i >= 0; i--) step(rnd_trig && ($urandom_range(0, 3) == 0), code[i]);
    step(rnd_trig && ($urandom_range(0, 3) == 0), 1'b0);
  endtask

  initial begin
    #2 rst = 1'b0;
    @(negedge clk);
    #1;

    // Single trigger on the first edge after reset
    do_reset();
    step(1'b1, 1'b0);
    idle(30);
    chk_frame("single", 0, 0, 0);
    chk_start("single_start", 0, 2);
    step(1'b1, 1'b0);
    idle(25);
    chk_frame("second", 1, 1, 31);

    // Three consecutive triggers
    do_reset();
    idle(5);
    repeat (3) step(1'b1, 1'b0);
    idle(70);
    chk_frame("consec0", 0, 0, 5);
    chk_frame("consec1", 1, 1, 6);
    chk_frame("consec2", 2, 2, 7);
    chk_start("consec_start0", 0, 7);
    chk_start("consec_start1", 1, 26);
    chk_start("consec_start2", 2, 45);

    // Overflow: FIFO_DEPTH+3 triggers back-to-back
    do_reset();
    repeat (Depth + 3) step(1'b1, 1'b0);
    idle(200);
    chk("burst_frames", frames.size(), 9);
    chk_frame("burst_last", 8, 8, 8);
    step(1'b1, 1'b0);
    idle(25);
    chk_frame("burst_gap", 9, 11, 211);

    // ECR after 5 triggers
    do_reset();
    repeat (5) step(1'b1, 1'b0);
    send_cmd(Ecr, 1'b0);
    step(1'b1, 1'b0);
    idle(150);
    chk_frame("ecr", 5, 0, 15);

    // BCR, trigger two edges after decode
    do_reset();
    send_cmd(Bcr, 1'b0);
    idle(1);
    step(1'b1, 1'b0);
    idle(25);
    chk_frame("bcr", 0, 0, 1);

    // FLUSH mid-backlog
    do_reset();
    repeat (5) step(1'b1, 1'b0);
    send_cmd(Flush, 1'b0);
    idle(100);
    chk("flush_frames", frames.size(), 1);

    // Reset mid-frame
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("midframe_start", int'(dataout), 1);
    rst = 1'b0;
    #1;
    chk("midframe_reset", int'(dataout), 0);
    @(negedge clk);
    #1;

    // L1ID wrap over 257 frames
    do_reset();
    repeat (257) begin
      step(1'b1, 1'b0);
      idle(19);
    end
    idle(30);
    chk("wrap_frames", frames.size(), 257);
    chk_frame("wrap255", 255, 255, 236);
    chk_frame("wrap256", 256, 0, 0);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0: send_cmd(Ecr, 1'b1);
          1: send_cmd(Bcr, 1'b1);
          2: send_cmd(Flush, 1'b1);
          default: send_cmd(8'($urandom), 1'b1);
        endcase
      end else if (r == 1 && $urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0, 1'b0);
      end
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/off_chip_emulator.md
Name: off_chip_emulator

Overview:
- Emulates an off-chip front-end readout ASIC. It is the device-side model inside the emulation shell.
- Receives a trigger line and a serial command line, both synchronous to the 40 MHz bunch clock.
- Keeps bunch-crossing (BCID) and event (L1ID) counters and buffers triggered events in a FIFO.
- Serializes each buffered event as a parity-protected frame on a single data output.

Parameters:
- FIFO_DEPTH, 8, number of buffered trigger records; power of two, at least 2.
- CMD_ECR, 8'hA5, command code that clears the event counter.
- CMD_BCR, 8'h3C, command code that clears the BCID counter.
- CMD_FLUSH, 8'h5A, command code that empties the event FIFO.

Ports:
- clkin40  input  1  single system clock, 40 MHz; all logic runs on its rising edge.
- rst  input  1  asynchronous, active-low reset; every register is cleared while rst=0.
- trigger  input  1  level-sampled trigger; each rising clock edge with trigger=1 is one trigger.
- command  input  1  serial command line; idles at 0.
- dataout  output  1  registered serial event data; idles at 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - dataout=0; BCID=0; L1ID=0; FIFO empty.
  - Command receiver idle; serializer idle.
  - Operation starts on the first rising edge after rst returns to 1.
- BCID counter:
  - 8-bit; increments on every edge; wraps 255->0.
- Trigger capture:
  - An edge with trigger=1 forms a record {L1ID, BCID}, using both counter values before this edge's update.
  - The record is pushed into the FIFO on that edge.
  - L1ID (8-bit) increments on every trigger, accepted or dropped; wraps 255->0.
- FIFO full:
  - The record is dropped and FIFO contents are unchanged.
  - L1ID still increments, so the downstream sees a gap.
  - A push and a pop on the same edge are legal when the FIFO is full or empty: the full condition accepts the push; on an empty FIFO the record is not bypassed, it is popped later.
- Command receiver:
  - Idle while command=0. A 1 sampled while idle is the start bit.
  - The next 8 edges shift in a code, MSB first.
  - The code is decoded on the edge after the 8th bit; the receiver then returns to idle. Back-to-back commands are allowed.
- Command codes:
  - CMD_ECR: L1ID takes the value 0 on the decode edge.
  - CMD_BCR: BCID takes the value 0 on the decode edge.
  - CMD_FLUSH: FIFO is emptied on the decode edge.
  - Any other code is ignored.
- Commands coinciding with a trigger:
  - A trigger on an ECR or BCR decode edge captures the pre-clear values; the clear then wins over the increment.
  - A trigger on a FLUSH decode edge is also flushed.
  - FLUSH never aborts a frame in progress.
- Serializer:
  - When idle and the FIFO is non-empty, it pops one record.
  - Frame on dataout, one bit per clock, in order:
    - start bit 1;
    - L1ID[7:0], MSB first;
    - BCID[7:0], MSB first;
    - even-parity bit, the XOR of the 16 payload bits;
    - one guard bit 0.
  - Frame length is 19 cycles. The next start bit comes at the earliest on the cycle after the guard bit.
  - dataout is 0 whenever no frame is active.
- Latency and spacing:
  - Trigger sampled at edge N with the serializer idle and the FIFO empty: dataout=1 (start bit) from edge N+2.
  - L1ID MSB appears at N+3, parity at N+19, guard at N+20.
  - Consecutive frames from a backlogged FIFO have start bits exactly 19 cycles apart.
- Reset mid-frame: the frame is abandoned immediately and dataout goes to 0.

Test Plan:
- Reset, then one trigger pulse -> one frame with L1ID=0x00, BCID equal to the edge count since reset release (0 for the first edge), correct parity; L1ID=1 afterwards.
- 3 triggers on consecutive edges -> 3 frames, L1ID 0,1,2 and BCID n,n+1,n+2, start bits 19 cycles apart.
- FIFO_DEPTH+3 triggers back-to-back -> one record is popped to the serializer and 8 are buffered, so 9 frames are sent; the next frame after the drops shows an L1ID gap of 2.
- Serial command 1,1010_0101 (ECR) after 5 triggers -> the next trigger's frame carries L1ID=0x00.
- BCR command -> a trigger two edges after the decode edge carries BCID=0x01.
- 256 triggers with no commands -> L1ID wraps to 0x00 in the 257th frame; FLUSH issued mid-backlog -> the current frame completes, then dataout stays 0; rst=0 mid-frame -> dataout=0 at once.
